// File: rtl/UART_pkg.sv
// ---------------------------------------------------------------------------
// UART_pkg : shared UART constants and the config-request FSM state type.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package UART_pkg;

  // 10 ms at a 50 MHz system clock
  localparam int COUNT_10MS  = 500_000;
  localparam int COUNT_STUCK = 2 * COUNT_10MS;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    LOW_CNT      = 3'd1,
    WAIT_RELEASE = 3'd2,
    REQ          = 3'd3,
    STUCK        = 3'd4
  } cfg_req_fsm_e;

endpackage : UART_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for a single asynchronous input.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/cfg_req_detector.sv
// ---------------------------------------------------------------------------
// cfg_req_detector : detects a long low "break" on the UART RX line as a
// configuration request, and flags a line stuck low. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cfg_req_detector
  import UART_pkg::*;
#(
  parameter int REQ_COUNT   = COUNT_10MS,
  parameter int STUCK_COUNT = 2 * COUNT_10MS
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic rx_i,
  input  logic enable_i,
  input  logic req_ackn_i,
  output logic config_req_slv_o,
  output logic frame_discard_o,
  output logic rx_inhibit_o,
  output logic line_fault_o
);

  localparam int c_cnt_w = $clog2(STUCK_COUNT + 1);
  localparam logic [c_cnt_w-1:0] c_req_last   = c_cnt_w'(REQ_COUNT - 1);
  localparam logic [c_cnt_w-1:0] c_stuck_last = c_cnt_w'(STUCK_COUNT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max    = c_cnt_w'(STUCK_COUNT);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  generate
    if (STUCK_COUNT <= REQ_COUNT || REQ_COUNT < 2) begin : g_param_check
      $error("cfg_req_detector: requires REQ_COUNT >= 2 and STUCK_COUNT > REQ_COUNT");
    end
  endgenerate

  logic               w_rx_s;
  cfg_req_fsm_e       r_state;
  cfg_req_fsm_e       w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic               r_req;
  logic               r_discard;
  logic               r_inhibit;
  logic               r_fault;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_d     (rx_i),
    .o_q     (w_rx_s)
  );

  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (enable_i && !w_rx_s) begin
          w_state_nxt = LOW_CNT;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      LOW_CNT: begin
        if (!enable_i || w_rx_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == c_req_last) w_state_nxt = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!enable_i) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_rx_s) begin
          w_state_nxt = REQ;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == c_stuck_last) w_state_nxt = STUCK;
        end
      end
      // enable_i is deliberately ignored here: only the acknowledge releases a request
      REQ: begin
        w_cnt_nxt = '0;
        if (req_ackn_i) w_state_nxt = IDLE;
      end
      STUCK: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_req     <= 1'b0;
      r_discard <= 1'b0;
      r_inhibit <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_req     <= (w_state_nxt == REQ);
      r_discard <= (r_state == LOW_CNT) && (w_state_nxt == WAIT_RELEASE);
      r_inhibit <= (w_state_nxt == WAIT_RELEASE) || (w_state_nxt == REQ) ||
                   (w_state_nxt == STUCK);
      if ((r_state != STUCK) && (w_state_nxt == STUCK)) begin
        r_fault <= 1'b1;
      end else if (req_ackn_i) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign config_req_slv_o = r_req;
  assign frame_discard_o  = r_discard;
  assign rx_inhibit_o     = r_inhibit;
  assign line_fault_o     = r_fault;

endmodule : cfg_req_detector

`default_nettype wire

// File: tb/tb_cfg_req_detector.sv
// ---------------------------------------------------------------------------
// tb_cfg_req_detector : scoreboard bench for cfg_req_detector (REQ=20, STUCK=40).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cfg_req_detector;

  localparam int REQ_N   = 20;
  localparam int STUCK_N = 40;

  // Event kinds, listed in the order the monitor reports same-cycle events.
  localparam int EV_DISC  = 0;
  localparam int EV_INH_R = 1;
  localparam int EV_INH_F = 2;
  localparam int EV_REQ_R = 3;
  localparam int EV_REQ_F = 4;
  localparam int EV_FLT_R = 5;
  localparam int EV_FLT_F = 6;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic en    = 1'b0;
  logic ack   = 1'b0;
  logic req;
  logic disc;
  logic inh;
  logic flt;

  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];
  logic p_req = 1'b0;
  logic p_inh = 1'b0;
  logic p_flt = 1'b0;

  cfg_req_detector #(
    .REQ_COUNT   (REQ_N),
    .STUCK_COUNT (STUCK_N)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .rx_i             (rx),
    .enable_i         (en),
    .req_ackn_i       (ack),
    .config_req_slv_o (req),
    .frame_discard_o  (disc),
    .rx_inhibit_o     (inh),
    .line_fault_o     (flt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1);
  end

  task automatic expect_ev(input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output-edge monitor: each observed event is popped against the scoreboard.
  always @(posedge clk) begin : mon
    int  seen[$];
    ev_t e;
    cyc = cyc + 1;
    #1;
    seen = {};
    if (disc === 1'b1)                     seen.push_back(EV_DISC);
    if (inh === 1'b1 && p_inh !== 1'b1)    seen.push_back(EV_INH_R);
    if (inh !== 1'b1 && p_inh === 1'b1)    seen.push_back(EV_INH_F);
    if (req === 1'b1 && p_req !== 1'b1)    seen.push_back(EV_REQ_R);
    if (req !== 1'b1 && p_req === 1'b1)    seen.push_back(EV_REQ_F);
    if (flt === 1'b1 && p_flt !== 1'b1)    seen.push_back(EV_FLT_R);
    if (flt !== 1'b1 && p_flt === 1'b1)    seen.push_back(EV_FLT_F);
    p_req = req;
    p_inh = inh;
    p_flt = flt;
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL event_missing: kind %0d not seen by cycle %0d, required at cycle %0d",
               e.kind, cyc, e.cyc);
    end
    foreach (seen[i]) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL event_unexpected: got kind %0d at cycle %0d, required no event",
                 seen[i], cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== seen[i] || e.cyc !== cyc) begin
          n_fail++;
          $display("FAIL event_match: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                   seen[i], cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    en    = 1'b0;
    ack   = 1'b0;
    wait_n(3);
    n_checks++;
    if ({req, disc, inh, flt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000", {req, disc, inh, flt});
    end
    n_checks++;
    if (dut.w_rx_s !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_sync: got %b required 1", dut.w_rx_s);
    end
    rst_n = 1'b1;
    wait_n(4);
    n_checks++;
    if ({req, disc, inh, flt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got %b required 0000", {req, disc, inh, flt});
    end
  endtask

  // 19 low cycles must not qualify.
  task automatic test_short_pulse();
    en = 1'b1;
    wait_n(3);
    rx = 1'b0;
    wait_n(REQ_N - 1);
    rx = 1'b1;
    wait_n(10);
    n_checks++;
    if (req !== 1'b0) begin
      n_fail++;
      $display("FAIL short_pulse_req: got %b required 0", req);
    end
  endtask

  // Latency from the drive cycle d: first sync edge d+1, discard REQ_N+1 edges later.
  task automatic test_qualify();
    int d;
    int a;
    @(negedge clk);
    d  = cyc;
    rx = 1'b0;
    expect_ev(d + REQ_N + 2, EV_DISC);
    expect_ev(d + REQ_N + 2, EV_INH_R);
    wait_n(25);
    rx = 1'b1;
    expect_ev(d + 28, EV_REQ_R);
    wait_n(5);
    n_checks++;
    if ({req, inh} !== 2'b11) begin
      n_fail++;
      $display("FAIL qualify_levels: got req,inh=%b required 11", {req, inh});
    end
    en = 1'b0;
    wait_n(5);
    n_checks++;
    if (req !== 1'b1) begin
      n_fail++;
      $display("FAIL req_held_no_enable: got %b required 1", req);
    end
    ack = 1'b1;
    a   = cyc;
    expect_ev(a + 1, EV_INH_F);
    expect_ev(a + 1, EV_REQ_F);
    wait_n(1);
    ack = 1'b0;
    en  = 1'b1;
    wait_n(5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL qualify_pending: got %0d events outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_stuck();
    int d;
    int a;
    @(negedge clk);
    d  = cyc;
    rx = 1'b0;
    expect_ev(d + REQ_N + 2, EV_DISC);
    expect_ev(d + REQ_N + 2, EV_INH_R);
    expect_ev(d + STUCK_N + 2, EV_FLT_R);
    wait_n(60);
    rx = 1'b1;
    expect_ev(d + 63, EV_INH_F);
    wait_n(8);
    n_checks++;
    if ({flt, req} !== 2'b10) begin
      n_fail++;
      $display("FAIL stuck_levels: got flt,req=%b required 10", {flt, req});
    end
    ack = 1'b1;
    a   = cyc;
    expect_ev(a + 1, EV_FLT_F);
    wait_n(1);
    ack = 1'b0;
    wait_n(3);
    n_checks++;
    if (flt !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clear: got %b required 0", flt);
    end
  endtask

  task automatic test_enable_drop();
    int d;
    int a;
    @(negedge clk);
    rx = 1'b0;
    wait_n(10);
    en = 1'b0;
    wait_n(20);
    rx = 1'b1;
    wait_n(5);
    en = 1'b1;
    wait_n(3);
    n_checks++;
    if ({req, inh} !== 2'b00) begin
      n_fail++;
      $display("FAIL enable_drop_levels: got req,inh=%b required 00", {req, inh});
    end
    @(negedge clk);
    d  = cyc;
    rx = 1'b0;
    expect_ev(d + REQ_N + 2, EV_DISC);
    expect_ev(d + REQ_N + 2, EV_INH_R);
    wait_n(REQ_N);
    rx = 1'b1;
    expect_ev(d + REQ_N + 3, EV_REQ_R);
    wait_n(5);
    ack = 1'b1;
    a   = cyc;
    expect_ev(a + 1, EV_INH_F);
    expect_ev(a + 1, EV_REQ_F);
    wait_n(1);
    ack = 1'b0;
    wait_n(3);
  endtask

  task automatic test_reset_mid();
    int r;
    int q;
    @(negedge clk);
    rx = 1'b0;
    wait_n(15);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req, disc, inh, flt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_count: got %b required 0000", {req, disc, inh, flt});
    end
    wait_n(2);
    rst_n = 1'b1;
    r     = cyc;
    expect_ev(r + REQ_N + 2, EV_DISC);
    expect_ev(r + REQ_N + 2, EV_INH_R);
    wait_n(REQ_N);
    rx = 1'b1;
    expect_ev(r + REQ_N + 3, EV_REQ_R);
    wait_n(5);
    q = cyc;
    expect_ev(q + 1, EV_INH_F);
    expect_ev(q + 1, EV_REQ_F);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req, inh} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_async_req: got req,inh=%b required 00", {req, inh});
    end
    wait_n(2);
    rst_n = 1'b1;
    wait_n(3);
  endtask

  // Back-to-back 8N1 0x00 frames at 2 cycles/bit: 18 low, 2 high stop.
  task automatic test_frame_00();
    for (int f = 0; f < 3; f++) begin
      rx = 1'b0;
      wait_n(18);
      rx = 1'b1;
      wait_n(2);
    end
    wait_n(10);
    n_checks++;
    if ({req, inh} !== 2'b00) begin
      n_fail++;
      $display("FAIL frame_00_levels: got req,inh=%b required 00", {req, inh});
    end
  endtask

  // Acknowledge and a synchronized falling edge land on the same FSM cycle.
  task automatic test_ack_collision();
    int d;
    int a;
    @(negedge clk);
    d  = cyc;
    rx = 1'b0;
    expect_ev(d + REQ_N + 2, EV_DISC);
    expect_ev(d + REQ_N + 2, EV_INH_R);
    wait_n(REQ_N);
    rx = 1'b1;
    expect_ev(d + REQ_N + 3, EV_REQ_R);
    wait_n(6);
    @(negedge clk);
    d  = cyc;
    rx = 1'b0;
    wait_n(2);
    ack = 1'b1;
    expect_ev(d + 3, EV_INH_F);
    expect_ev(d + 3, EV_REQ_F);
    wait_n(1);
    ack = 1'b0;
    expect_ev(d + 23, EV_DISC);
    expect_ev(d + 23, EV_INH_R);
    wait_n(18);
    rx = 1'b1;
    expect_ev(d + 24, EV_REQ_R);
    wait_n(5);
    n_checks++;
    if (req !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_req: got %b required 1", req);
    end
    ack = 1'b1;
    a   = cyc;
    expect_ev(a + 1, EV_INH_F);
    expect_ev(a + 1, EV_REQ_F);
    wait_n(1);
    ack = 1'b0;
    wait_n(4);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_pending: got %0d events outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_short_pulse();
    test_qualify();
    test_stuck();
    test_enable_drop();
    test_reset_mid();
    test_frame_00();
    test_ack_collision();
    wait_n(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cfg_req_detector

`default_nettype wire
